// File: rtl/hps_kms_decoder.sv
// Decodes the toggle-level KMS event stream into mouse counters, a keyboard FIFO and an OSD strobe.
// Optional keyboard-reset tracking (Ctrl+LAmiga+RAmiga) is compiled in with KMS_KBD_RESET_EN.
module hps_kms_decoder #(
    parameter int unsigned FIFO_AW = 3
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       kms_level,
    input  logic [1:0] kms_type,
    input  logic [7:0] kms_data,
    output logic [7:0] mouse_x,
    output logic [7:0] mouse_y,
    output logic       kbd_valid,
    output logic [7:0] kbd_data,
    input  logic       kbd_rd,
    output logic       kbd_ovf,
    input  logic       ovf_clr,
    output logic [7:0] osd_key,
    output logic       osd_stb,
    output logic       kbd_reset
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] PTR_ONE = 1;

    typedef enum logic [1:0] {
        EV_MOUSE_X = 2'd0,
        EV_MOUSE_Y = 2'd1,
        EV_KEY     = 2'd2,
        EV_OSD     = 2'd3
    } ev_type_e;

    logic             lvl_q;
    logic             armed_q;
    logic [7:0]       mouse_x_q;
    logic [7:0]       mouse_y_q;
    logic [FIFO_AW:0] wr_ptr_q;
    logic [FIFO_AW:0] rd_ptr_q;
    logic [7:0]       mem_q [DEPTH];
    logic             ovf_q;
    logic [7:0]       osd_key_q;
    logic             osd_stb_q;

    logic evt;
    logic empty;
    logic full;
    logic pop;
    logic push_req;
    logic push;
    logic drop;

    always_comb begin
        evt      = armed_q & (kms_level ^ lvl_q);
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                   (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
        pop      = kbd_rd & ~empty;
        push_req = evt & (ev_type_e'(kms_type) == EV_KEY);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
        push     = push_req & (~full | pop);
        drop     = push_req & full & ~pop;
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem_q[wr_ptr_q[FIFO_AW-1:0]] <= kms_data;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            lvl_q     <= 1'b0;
            armed_q   <= 1'b0;
            mouse_x_q <= '0;
            mouse_y_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_q     <= 1'b0;
            osd_key_q <= '0;
            osd_stb_q <= 1'b0;
        end else begin
            lvl_q     <= kms_level;
            armed_q   <= 1'b1;
            osd_stb_q <= 1'b0;
            if (evt) begin
                case (ev_type_e'(kms_type))
                    EV_MOUSE_X: mouse_x_q <= mouse_x_q + kms_data;
                    EV_MOUSE_Y: mouse_y_q <= mouse_y_q + kms_data;
                    EV_OSD: begin
                        osd_key_q <= kms_data;
                        osd_stb_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (drop)         ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

    assign mouse_x   = mouse_x_q;
    assign mouse_y   = mouse_y_q;
    assign kbd_valid = ~empty;
    assign kbd_data  = empty ? '0 : mem_q[rd_ptr_q[FIFO_AW-1:0]];
    assign kbd_ovf   = ovf_q;
    assign osd_key   = osd_key_q;
    assign osd_stb   = osd_stb_q;

`ifdef KMS_KBD_RESET_EN
    // held bits: [0] Ctrl 0x63, [1] LAmiga 0x66, [2] RAmiga 0x67; bit7 of the code marks a break
    logic [2:0] held_q;
    logic [2:0] held_d;
    logic       kbd_reset_q;

    always_comb begin
        held_d = held_q;
        if (push_req) begin
            case (kms_data[6:0])
                7'h63:   held_d[0] = ~kms_data[7];
                7'h66:   held_d[1] = ~kms_data[7];
                7'h67:   held_d[2] = ~kms_data[7];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            held_q      <= '0;
            kbd_reset_q <= 1'b0;
        end else begin
            held_q      <= held_d;
            kbd_reset_q <= &held_d;
        end
    end

    assign kbd_reset = kbd_reset_q;
`else
    assign kbd_reset = 1'b0;
`endif

endmodule
